// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core datapath: write-destination select codes,
// architectural register numbers and a saturating counter helper.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [1:0] WDST_RT  = 2'b00;
    localparam logic [1:0] WDST_RD  = 2'b01;
    localparam logic [1:0] WDST_RA  = 2'b10;
    localparam logic [1:0] WDST_BAD = 2'b11;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/mips_reg_file_wr_write_dst_select.sv
// Write-destination demultiplexer: picks rt, rd or $ra as the write address and
// flags whether the result names a writable register.
module write_dst_select
    import mips_pkg::*;
(
    input  logic [1:0]            wdst_sel,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic                  valid
);

    // 3-to-1 address select; the illegal code maps to $0 so it can never land.
    always_comb begin
        waddr = REG_ZERO;
        valid = 1'b0;
        case (wdst_sel)
            WDST_RT: waddr = rt;
            WDST_RD: waddr = rd;
            WDST_RA: waddr = REG_RA;
            default: waddr = REG_ZERO;
        endcase
        valid = (wdst_sel != WDST_BAD) && (waddr != REG_ZERO);
    end

endmodule

// File: rtl/mips_reg_file_wr.sv
// 32 x DATA_W register file with a steered write port, two combinational read
// ports (optional same-cycle bypass), a saturating commit counter and a sticky
// illegal-destination flag.
module mips_reg_file_wr
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic [1:0]            wdst_sel,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_ADDR_W-1:0] read_reg1,
    input  logic [REG_ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0]     read_data1,
    output logic [DATA_W-1:0]     read_data2,
    output logic [15:0]           wr_count,
    output logic                  dst_err
);

    logic [REG_ADDR_W-1:0] waddr_s;
    logic                  valid_s;
    logic                  commit_s;
    logic                  bad_sel_s;
    logic [DATA_W-1:0]     read_data1_s;
    logic [DATA_W-1:0]     read_data2_s;
    logic [DATA_W-1:0]     regs_r [NUM_REGS];
    logic [15:0]           wr_count_r;
    logic                  dst_err_r;

    write_dst_select u_write_dst_select (
        .wdst_sel (wdst_sel),
        .rt       (rt),
        .rd       (rd),
        .waddr    (waddr_s),
        .valid    (valid_s)
    );

    // Reset masks the commit so neither the array nor the bypass sees a write.
    assign commit_s  = reg_write && valid_s && !reset;
    assign bad_sel_s = reg_write && (wdst_sel == WDST_BAD);

    // Register array; entry 0 is cleared on reset and never addressed by a commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (commit_s) begin
            regs_r[waddr_s] <= write_data;
        end
    end

    // Saturating count of committed writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count_r <= 16'd0;
        end else if (commit_s) begin
            wr_count_r <= sat_inc16(wr_count_r);
        end
    end

    // Sticky illegal-destination flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dst_err_r <= 1'b0;
        end else if (bad_sel_s) begin
            dst_err_r <= 1'b1;
        end
    end

    // Read ports: $0 is hard-wired to zero ahead of the bypass check.
    always_comb begin
        read_data1_s = regs_r[read_reg1];
        read_data2_s = regs_r[read_reg2];
        if (read_reg1 == REG_ZERO) begin
            read_data1_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && commit_s && (read_reg1 == waddr_s)) begin
            read_data1_s = write_data;
        end else begin
            read_data1_s = regs_r[read_reg1];
        end
        if (read_reg2 == REG_ZERO) begin
            read_data2_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && commit_s && (read_reg2 == waddr_s)) begin
            read_data2_s = write_data;
        end else begin
            read_data2_s = regs_r[read_reg2];
        end
    end

    assign read_data1 = read_data1_s;
    assign read_data2 = read_data2_s;
    assign wr_count   = wr_count_r;
    assign dst_err    = dst_err_r;

endmodule
